// File: rtl/pid_param.sv
// pid_param: two-stage pipelined PID steering controller.
// Inputs are a signed heading error and an unsigned forward speed. Outputs are
// signed left/right wheel speeds with a one-cycle valid strobe, two edges after
// the error strobe.
// Optional feature macro: PID_INT_CLAMP_EN. When defined, an integrator overflow
// saturates to the signed INT_W limit. When undefined, the integrator holds its
// previous value on overflow.
module pid_param #(
  parameter int ERR_W   = 12,
  parameter int SAT_W   = 10,
  parameter int FRWRD_W = 10,
  parameter int SPD_W   = 11,
  parameter int INT_W   = 15,
  parameter int I_SHIFT = 6,
  parameter int D_LAG   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     moving,
  input  logic                     err_vld,
  input  logic signed [ERR_W-1:0]  error,
  input  logic [FRWRD_W-1:0]       frwrd,
  input  logic [5:0]               p_coeff,
  input  logic [4:0]               d_coeff,
  output logic signed [SPD_W-1:0]  lft_spd,
  output logic signed [SPD_W-1:0]  rght_spd,
  output logic                     spd_vld
);

  localparam int P_W   = SAT_W + 6;   // P term width
  localparam int DD_W  = SAT_W + 1;   // raw derivative difference width
  localparam int DT_W  = 14;          // 8-bit clamped diff times 6-bit zero-extended gain
  localparam int PID_W = SAT_W + 7;   // PID sum width
  localparam int LR_W  = SPD_W + 2;   // pre-clamp wheel speed width

  localparam logic signed [ERR_W-1:0] SAT_HI = ERR_W'((1 << (SAT_W - 1)) - 1);
  localparam logic signed [ERR_W-1:0] SAT_LO = ~SAT_HI;
  localparam logic signed [DD_W-1:0]  DCL_HI = DD_W'(127);
  localparam logic signed [DD_W-1:0]  DCL_LO = ~DCL_HI;
  localparam logic signed [LR_W-1:0]  SPD_HI = LR_W'((1 << (SPD_W - 1)) - 1);
  localparam logic signed [LR_W-1:0]  SPD_LO = ~SPD_HI;
`ifdef PID_INT_CLAMP_EN
  localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W - 1){1'b1}}};
  localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W - 1){1'b0}}};
`endif

  // Error history and stage-1 registers
  logic signed [SAT_W-1:0] hist_q [D_LAG];
  logic signed [SAT_W-1:0] hist_d [D_LAG];
  logic signed [P_W-1:0]   p_term_q, p_term_d;
  logic signed [DT_W-1:0]  d_term_q, d_term_d;
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic [FRWRD_W-1:0]      frwrd_q, frwrd_d;
  logic                    s1_vld_q, s1_vld_d;

  // Output registers
  logic signed [SPD_W-1:0] lft_spd_q, lft_spd_d;
  logic signed [SPD_W-1:0] rght_spd_q, rght_spd_d;
  logic                    spd_vld_q, spd_vld_d;

  // Combinational datapath
  logic signed [SAT_W-1:0] err_sat;
  logic signed [P_W-1:0]   p_term;
  logic signed [DD_W-1:0]  d_diff;
  logic signed [7:0]       d_sat;
  logic signed [DT_W-1:0]  d_term;
  logic signed [INT_W-1:0] int_sum;
  logic                    int_ovf;
  logic signed [INT_W-1:0] int_upd;
  logic signed [INT_W-1:0] i_term;
  logic signed [PID_W-1:0] pid;
  logic signed [LR_W-1:0]  steer;
  logic signed [LR_W-1:0]  lft_full, rght_full;
  logic signed [SPD_W-1:0] lft_sat, rght_sat;

  // Clamp the raw error into the signed SAT_W range
  always_comb begin
    err_sat = error[SAT_W-1:0];
    if (error > SAT_HI) begin
      err_sat = SAT_HI[SAT_W-1:0];
    end else if (error < SAT_LO) begin
      err_sat = SAT_LO[SAT_W-1:0];
    end
  end

  // P and D terms; the derivative compares against the oldest history entry
  always_comb begin
    p_term = P_W'(err_sat) * P_W'($signed({1'b0, p_coeff}));
    d_diff = DD_W'(err_sat) - DD_W'(hist_q[D_LAG-1]);
    d_sat  = d_diff[7:0];
    if (d_diff > DCL_HI) begin
      d_sat = DCL_HI[7:0];
    end else if (d_diff < DCL_LO) begin
      d_sat = DCL_LO[7:0];
    end
    d_term = DT_W'(d_sat) * DT_W'($signed({1'b0, d_coeff}));
  end

  // Integrator accumulate with signed overflow detection
  always_comb begin
    int_sum = integ_q + INT_W'(err_sat);
    int_ovf = (integ_q[INT_W-1] == err_sat[SAT_W-1]) &&
              (int_sum[INT_W-1] != integ_q[INT_W-1]);
`ifdef PID_INT_CLAMP_EN
    int_upd = int_ovf ? (integ_q[INT_W-1] ? INT_MIN : INT_MAX) : int_sum;
`else
    int_upd = int_ovf ? integ_q : int_sum;
`endif
  end

  // History shift: each tap loads its upstream neighbour on a sample
  for (genvar gi = 0; gi < D_LAG; gi++) begin : g_hist
    logic signed [SAT_W-1:0] src;
    if (gi == 0) begin : g_head
      assign src = err_sat;
    end else begin : g_tail
      assign src = hist_q[gi-1];
    end
    assign hist_d[gi] = !moving ? '0 : (err_vld ? src : hist_q[gi]);

    // History tap register
    always_ff @(posedge clk) begin
      if (rst) begin
        hist_q[gi] <= '0;
      end else begin
        hist_q[gi] <= hist_d[gi];
      end
    end
  end

  // Stage-1 next state: clear when stopped, load on a sample, otherwise hold
  always_comb begin
    p_term_d = p_term_q;
    d_term_d = d_term_q;
    integ_d  = integ_q;
    frwrd_d  = frwrd_q;
    s1_vld_d = 1'b0;
    if (!moving) begin
      p_term_d = '0;
      d_term_d = '0;
      integ_d  = '0;
      frwrd_d  = '0;
      s1_vld_d = err_vld;
    end else if (err_vld) begin
      p_term_d = p_term;
      d_term_d = d_term;
      integ_d  = int_upd;
      frwrd_d  = frwrd;
      s1_vld_d = 1'b1;
    end
  end

  // Stage-2 arithmetic: combine terms, steer, and clamp each wheel speed
  always_comb begin
    i_term    = integ_q >>> I_SHIFT;
    pid       = PID_W'(p_term_q >>> 1) + PID_W'(i_term) + PID_W'(d_term_q);
    steer     = LR_W'(pid >>> 3);
    lft_full  = LR_W'($signed({1'b0, frwrd_q})) + steer;
    rght_full = LR_W'($signed({1'b0, frwrd_q})) - steer;
    lft_sat   = lft_full[SPD_W-1:0];
    rght_sat  = rght_full[SPD_W-1:0];
    if (lft_full > SPD_HI) begin
      lft_sat = SPD_HI[SPD_W-1:0];
    end else if (lft_full < SPD_LO) begin
      lft_sat = SPD_LO[SPD_W-1:0];
    end
    if (rght_full > SPD_HI) begin
      rght_sat = SPD_HI[SPD_W-1:0];
    end else if (rght_full < SPD_LO) begin
      rght_sat = SPD_LO[SPD_W-1:0];
    end
  end

  // Output next state: zero when stopped, strobe still follows stage 1
  always_comb begin
    lft_spd_d  = lft_spd_q;
    rght_spd_d = rght_spd_q;
    spd_vld_d  = 1'b0;
    if (!moving) begin
      lft_spd_d  = '0;
      rght_spd_d = '0;
      spd_vld_d  = s1_vld_q;
    end else if (s1_vld_q) begin
      lft_spd_d  = lft_sat;
      rght_spd_d = rght_sat;
      spd_vld_d  = 1'b1;
    end
  end

  // Pipeline and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      p_term_q   <= '0;
      d_term_q   <= '0;
      integ_q    <= '0;
      frwrd_q    <= '0;
      s1_vld_q   <= 1'b0;
      lft_spd_q  <= '0;
      rght_spd_q <= '0;
      spd_vld_q  <= 1'b0;
    end else begin
      p_term_q   <= p_term_d;
      d_term_q   <= d_term_d;
      integ_q    <= integ_d;
      frwrd_q    <= frwrd_d;
      s1_vld_q   <= s1_vld_d;
      lft_spd_q  <= lft_spd_d;
      rght_spd_q <= rght_spd_d;
      spd_vld_q  <= spd_vld_d;
    end
  end

  assign lft_spd  = lft_spd_q;
  assign rght_spd = rght_spd_q;
  assign spd_vld  = spd_vld_q;

endmodule

// File: doc/pid_param.md
# pid_param

Parametrised, pipelined PID steering controller, the next-generation drop-in for the fixed-width heading PID. It converts a signed heading error and an unsigned forward speed into signed left and right wheel speeds. Gains are run-time programmable, the derivative lag depth is configurable, and outputs carry a valid strobe. It sits between the heading-error source and the motor PWM drivers.

## Interface
- ERR_W, 12, raw error width (signed)
- SAT_W, 10, saturated error width (signed), SAT_W < ERR_W
- FRWRD_W, 10, forward speed width (unsigned), FRWRD_W < SPD_W
- SPD_W, 11, wheel speed output width (signed)
- INT_W, 15, integrator width (signed)
- I_SHIFT, 6, integrator right-shift to form I term
- D_LAG, 3, derivative history depth, 1..8

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- moving  in  1  controller enable; low clears state and zeroes outputs
- err_vld  in  1  error sample strobe
- error  in  ERR_W  signed heading error
- frwrd  in  FRWRD_W  unsigned forward speed
- p_coeff  in  6  unsigned P gain
- d_coeff  in  5  unsigned D gain
- lft_spd  out  SPD_W  signed left speed, registered
- rght_spd  out  SPD_W  signed right speed, registered
- spd_vld  out  1  one-cycle strobe: lft_spd/rght_spd updated

## Operation
- err_sat: clamp error to signed SAT_W range [-2^(SAT_W-1), 2^(SAT_W-1)-1].
- P: P_term = err_sat × zero-extended p_coeff, SAT_W+6 bits signed.
- D: shift register hist[0..D_LAG-1] of err_sat, shifts on err_vld. D_diff = err_sat − hist[D_LAG-1] (SAT_W+1 bits). Clamp to signed 8 bits [-128,127]. D_term = D_diff_sat × zero-extended d_coeff.
- I: on err_vld & moving: sum = integrator + sign-extended err_sat. On signed overflow (operands same sign, sum differs), integrator holds its value. Otherwise it takes sum. I_term = integrator >>> I_SHIFT.
- Stage 1 (edge after err_vld): register P_term, D_term, updated integrator, frwrd, and a valid bit.
- Stage 2: compute PID = (P_term >>> 1) + I_term + D_term, sign-extended to PID_W = SAT_W+7. steer = PID >>> 3. lft = frwrd + steer, rght = frwrd − steer, both in SPD_W+2 signed. Clamp each to the signed SPD_W range and register into lft_spd/rght_spd. Pulse spd_vld.
- moving low: on the next edge, integrator, hist, stage-1 registers and lft_spd/rght_spd are cleared to 0. While moving is low, spd_vld still pulses for each err_vld, with outputs 0.
- No err_vld: pipeline registers and outputs hold. spd_vld = 0.

## Timing
- Latency: err_vld at edge N → lft_spd/rght_spd/spd_vld valid after edge N+2.
- Throughput: err_vld accepted every cycle, back-to-back, no stall.
- p_coeff/d_coeff/frwrd are sampled with err_vld at stage 1. Changes between samples have no effect until the next sample.
- Reset: lft_spd = 0, rght_spd = 0, spd_vld = 0, integrator = 0, hist = 0, all stage registers = 0.
- Reset mid-stream: samples in flight are discarded. No spd_vld occurs for them.
- err_vld and moving falling on the same edge: clear wins. The integrator is not updated.

## Configuration
- PID_INT_CLAMP_EN defined: on overflow, the integrator saturates to +2^(INT_W-1)-1 or -2^(INT_W-1), matching the sign of the operands.
- PID_INT_CLAMP_EN not defined: on overflow, the integrator freezes at its previous value (default).

## Test plan
- Basic (defaults): p=16, d=7, frwrd=256, zero history, one err_vld with error=0x100. After 2 edges: lft_spd=623, rght_spd=−111, spd_vld=1 for one cycle.
- Saturation: error=0x7FF, p=63, d=7, frwrd=1000, fresh state. err_sat=511 and steer=2124. lft_spd=1023, rght_spd=−1024.
- D lag: D_LAG=3, p=0, d=1, errors 10, 20, 30, 40 on successive err_vld. D_diff sequence is 10, 20, 30, 30. Fourth D_diff = 40−10.
- Integrator overflow: error=0x1FF with err_vld every cycle. Integrator reaches 16352 after 32 samples. Without the macro it holds at 16352. With PID_INT_CLAMP_EN it saturates to 16383.
- moving drop: mid-stream, moving=0 for one edge. On the next edge, integrator=0, hist=0 and outputs=0. After moving=1 and a new sample, the first result matches the fresh-state result.
- Reset mid-pipeline: rst pulsed on the edge after err_vld. No spd_vld follows, and all outputs read 0.
